bidir_bus_ctrl: RTL and testbench
=================================

# bidir_bus_ctrl

Sequencing controller for the A-side endpoint of the 8-bit bidirectional buffer array. It owns the direction/enable pins of the buffer array (`ce`, `sr`) and moves single bytes across the shared bus. Writes (A→B) and reads (B→A) are queued through simple handshakes. The block enforces a dead-time turnaround whenever the bus direction flips, so the two drivers never overlap. The tristate itself lives at the top level: this block provides `bus_out`/`bus_oe` and samples `bus_in`.

## Interface
- `TURN_CYC`, 1, number of turnaround cycles with `ce`=0 on a direction change; legal range 1..15.

- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `wr_valid`  in  1  write byte offered
- `wr_data`  in  8  byte to drive onto the bus
- `wr_ready`  out  1  write accepted when `wr_valid`&`wr_ready`
- `rd_req`  in  1  read request level; held until `rd_valid` is seen
- `rd_valid`  out  1  one-cycle pulse, `rd_data` valid
- `rd_data`  out  8  byte sampled from the bus
- `ce`  out  1  buffer-array chip enable
- `sr`  out  1  buffer-array direction: 1 = A→B (transmit), 0 = B→A (receive)
- `bus_out`  out  8  A-side drive value
- `bus_oe`  out  1  A-side tristate enable
- `bus_in`  in  8  A-side bus value

## Operation
- States:
  - IDLE: `ce`=0, `bus_oe`=0.
  - TURN: `ce`=0, `bus_oe`=0, counting down.
  - DRIVE: `ce`=1, `sr`=1, `bus_oe`=1.
  - SAMPLE: `ce`=1, `sr`=0, `bus_oe`=0.
- `ce`, `sr`, and `bus_oe` are decoded from registers only. There is no combinational path from any input.
- Arbitration in IDLE:
  - Selects write if `wr_valid` and (no `rd_req` or `last_op`=read).
  - Otherwise selects read if `rd_req`.
  - `last_op` resets to read, so the first contention goes to write.
- Write accept: `wr_ready`=1 only in IDLE when write is selected. `wr_data` is latched into `bus_out` in that cycle.
- Read accept: `rd_req` is taken in IDLE when read is selected. `rd_req` is ignored in any cycle where `rd_valid`=1.
- Routing after accept:
  - If the selected direction equals current `sr`, go straight to DRIVE/SAMPLE.
  - Otherwise, load `sr` with the new direction, load the counter with `TURN_CYC`, and go to TURN.
- TURN: the counter decrements each cycle. When it reaches 1, go to DRIVE or SAMPLE.
- DRIVE lasts 1 cycle, then goes to IDLE.
- SAMPLE lasts 1 cycle. `bus_in` is captured into `rd_data` at the closing edge, then `rd_valid`=1 for the following cycle (IDLE).
- `sr` changes only on the edge entering TURN, which always happens while `ce`=0. `sr` holds its last value in IDLE.
- `bus_oe`=1 implies `ce`=1 and `sr`=1, always.
- Each transfer takes at least 2 cycles because `ce` drops between bytes. Same-direction streams never insert TURN.

## Timing
- Reset values: state IDLE, `ce`=0, `sr`=0, `bus_oe`=0, `bus_out`=0x00, `rd_data`=0x00, `rd_valid`=0, `wr_ready`=0, `last_op`=read, counter=0.
- Reset mid-operation:
  - All outputs take their reset values immediately (asynchronously).
  - An in-flight byte is dropped, and no `rd_valid` is issued.
  - The requester must re-present the byte.
- Write, same direction: accept cycle N; DRIVE cycle N+1; IDLE N+2. Next accept at N+2.
- Write, direction flip: accept N; TURN N+1..N+TURN_CYC; DRIVE N+TURN_CYC+1.
- Read, same direction: accept N; SAMPLE N+1; `rd_valid` N+2.
- Read, direction flip: SAMPLE at N+TURN_CYC+1; `rd_valid` at N+TURN_CYC+2.
- Simultaneous `wr_valid` and `rd_req` held: grants alternate W,R,W,..., with TURN before each.
- `wr_valid` dropping while `wr_ready`=0 is legal; nothing is latched.

## Test plan
- Reset: pulse `rst` between clock edges. Every output equals its reset value within the same cycle; `sr`=0.
- First write after reset (`TURN_CYC`=1), `wr_data`=0xA5:
  - `wr_ready`=1 at cycle 0.
  - Cycle 1: `sr`=1, `ce`=0.
  - Cycle 2: `ce`=1, `bus_oe`=1, `bus_out`=0xA5.
  - Cycle 3: `ce`=0.
- Back-to-back writes 0x01, 0x02 with `wr_valid` held: DRIVE with 0x01, then 0x02, two cycles apart. No TURN between them; `sr` stays 1.
- Read after write (`TURN_CYC`=3), `bus_in`=0x3C:
  - Exactly 3 cycles with `ce`=0 and `sr`=0 before SAMPLE.
  - `rd_data`=0x3C with a single-cycle `rd_valid`.
  - `bus_oe`=0 throughout.
- Contention: `wr_valid`=1 (0x11) and `rd_req`=1 held from reset. Grant order is write, read, write; TURN precedes each transfer. Assertion never fires: `bus_oe`&!`sr`, or `sr` change while `ce`=1.
- Assert `rst` during DRIVE: `ce` and `bus_oe` fall immediately, and no `wr_ready` or `rd_valid` pulses occur until requests are re-presented after release.

Source files
------------

// File: rtl/bidir_bus_ctrl_if.sv
// ----------------------------------------------------------------------------
// bidir_bus_ctrl_if
//   Bundles the request handshakes and the buffer-array pins of the A-side
//   bus controller.
//
//   Signals
//     wr_valid / wr_data / wr_ready : write byte handshake (A->B)
//     rd_req / rd_valid / rd_data   : read request level and result pulse (B->A)
//     ce, sr                        : buffer-array chip enable and direction
//     bus_out, bus_oe, bus_in       : A-side tristate drive value, enable, sample
//
//   Modports
//     slave  : the controller (bidir_bus_ctrl)
//     master : the requester / top-level environment
// ----------------------------------------------------------------------------
interface bidir_bus_ctrl_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_req;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       ce;
  logic       sr;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] bus_in;

  modport slave (
    input  wr_valid, wr_data, rd_req, bus_in,
    output wr_ready, rd_valid, rd_data, ce, sr, bus_out, bus_oe
  );

  modport master (
    output wr_valid, wr_data, rd_req, bus_in,
    input  wr_ready, rd_valid, rd_data, ce, sr, bus_out, bus_oe
  );
endinterface

// File: rtl/bidir_bus_ctrl.sv
// ----------------------------------------------------------------------------
// bidir_bus_ctrl
//   Sequencing controller for the A-side endpoint of an 8-bit bidirectional
//   buffer array. Moves single bytes across the shared bus, one transfer at a
//   time, and inserts TURN_CYC dead cycles (ce=0) whenever the direction flips
//   so the A-side and B-side drivers never overlap.
//
//   Parameters
//     TURN_CYC : turnaround cycles with ce=0 on a direction change (1..15)
//
//   Ports
//     clk  : clock, all state changes on the rising edge
//     rst  : asynchronous, active-high reset
//     bus  : bidir_bus_ctrl_if.slave (handshakes + buffer-array pins)
//
//   ce, sr and bus_oe are decoded from registers only. wr_ready is the one
//   output that depends on inputs: it is the IDLE-state grant of a write.
// ----------------------------------------------------------------------------
module bidir_bus_ctrl #(
  parameter int unsigned TURN_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  bidir_bus_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TURN   = 2'd1,
    DRIVE  = 2'd2,
    SAMPLE = 2'd3
  } state_t;

  localparam logic [3:0] TURN_LOAD = TURN_CYC[3:0];

  state_t     state;
  logic       dir_sr;       // current buffer direction, 1 = A->B
  logic       last_wr;      // last granted op was a write
  logic [3:0] turn_cnt;
  logic [7:0] bus_out_q;
  logic [7:0] rd_data_q;
  logic       rd_valid_q;

  logic rd_eff;
  logic wr_sel;
  logic rd_sel;

  // A read request seen in the rd_valid cycle is the tail of the request that
  // just completed, not a new one.
  assign rd_eff = bus.rd_req & ~rd_valid_q;

  // Write wins unless a read is pending and the previous grant was a write,
  // which gives strict alternation under contention.
  assign wr_sel = (state == IDLE) & bus.wr_valid & (~rd_eff | ~last_wr);
  assign rd_sel = (state == IDLE) & ~wr_sel & rd_eff;

  // NOTE: wr_ready is combinational from the inputs, so it must be gated by the
  // asynchronous reset explicitly; the registers alone cannot force it low.
  assign bus.wr_ready = wr_sel & ~rst;

  // NOTE: all state lives in one always_ff with non-blocking assignments and an
  // asynchronous reset, so every register updates together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dir_sr     <= 1'b0;
      last_wr    <= 1'b0;
      turn_cnt   <= 4'd0;
      bus_out_q  <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_sel || rd_sel) begin
            last_wr <= wr_sel;
            if (wr_sel) begin
              bus_out_q <= bus.wr_data;
            end
            if (wr_sel == dir_sr) begin
              state <= wr_sel ? DRIVE : SAMPLE;
            end else begin
              // Direction flips only here, while ce is already low.
              dir_sr   <= wr_sel;
              turn_cnt <= TURN_LOAD;
              state    <= TURN;
            end
          end
        end
        TURN: begin
          turn_cnt <= turn_cnt - 4'd1;
          if (turn_cnt == 4'd1) begin
            state <= dir_sr ? DRIVE : SAMPLE;
          end
        end
        DRIVE: begin
          state <= IDLE;
        end
        SAMPLE: begin
          rd_data_q  <= bus.bus_in;
          rd_valid_q <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ce       = (state == DRIVE) | (state == SAMPLE);
  assign bus.sr       = dir_sr;
  assign bus.bus_oe   = (state == DRIVE);
  assign bus.bus_out  = bus_out_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bidir_bus_ctrl
//   Two controllers (TURN_CYC=1 and TURN_CYC=3) receive identical stimulus.
//   The driver steps a timeline model of each: on every grant it pushes the
//   expected transfer (cycle, direction, byte) and, for reads, the expected
//   rd_valid (cycle, byte) into per-lane queues. A separate monitor pops and
//   compares whenever a DUT presents ce / rd_valid, and checks the per-cycle
//   grant, direction and safety properties.
// ----------------------------------------------------------------------------
module tb_bidir_bus_ctrl;

  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bidir_bus_ctrl_if if1 ();
  bidir_bus_ctrl_if if3 ();

  bidir_bus_ctrl #(.TURN_CYC(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  bidir_bus_ctrl #(.TURN_CYC(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  typedef struct {
    int         cyc;
    bit         is_w;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    int busy_until;   // first cycle the controller is free again
    bit dir;          // direction the buffer currently points
    bit last_w;       // last grant was a write
    int rdv_cyc;      // cycle carrying rd_valid (rd_req ignored there)
  } mdl_t;

  ev_t        evq [2][$];
  ev_t        rdq [2][$];
  mdl_t       mdl [2];
  bit         exp_wrr [2];
  bit         exp_sr [2];
  bit         prev_sr [2];
  bit         prev_ce [2];
  logic [7:0] bus_in_arr [MAXC];

  int cyc = 0;
  bit sim_done = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  function automatic int tc_of(input int ln);
    return (ln == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- driver --
  task automatic drive(input bit wv, input logic [7:0] wd, input bit rq);
    if1.wr_valid = wv;  if1.wr_data = wd;  if1.rd_req = rq;  if1.bus_in = bus_in_arr[cyc];
    if3.wr_valid = wv;  if3.wr_data = wd;  if3.rd_req = rq;  if3.bus_in = bus_in_arr[cyc];
  endtask

  task automatic model_reset();
    for (int ln = 0; ln < 2; ln++) begin
      mdl[ln].busy_until = 0;
      mdl[ln].dir        = 1'b0;
      mdl[ln].last_w     = 1'b0;
      mdl[ln].rdv_cyc    = -1;
      exp_wrr[ln]        = 1'b0;
      exp_sr[ln]         = 1'b0;
      evq[ln].delete();
      rdq[ln].delete();
    end
  endtask

  task automatic model_step(input int ln, input bit wv, input logic [7:0] wd, input bit rq);
    bit  rd_eff, ws, rs;
    int  lat, ev;
    ev_t e;
    exp_sr[ln] = mdl[ln].dir;
    rd_eff = rq && (cyc != mdl[ln].rdv_cyc);
    ws = 1'b0;
    rs = 1'b0;
    if (cyc >= mdl[ln].busy_until) begin
      ws = wv && (!rd_eff || !mdl[ln].last_w);
      rs = !ws && rd_eff;
    end
    exp_wrr[ln] = ws;
    if (ws || rs) begin
      lat    = (ws == mdl[ln].dir) ? 1 : tc_of(ln) + 1;
      ev     = cyc + lat;
      e.cyc  = ev;
      e.is_w = ws;
      e.data = ws ? wd : bus_in_arr[ev];
      evq[ln].push_back(e);
      if (rs) begin
        e.cyc = ev + 1;
        rdq[ln].push_back(e);
        mdl[ln].rdv_cyc = ev + 1;
      end
      mdl[ln].busy_until = ev + 1;
      mdl[ln].dir        = ws;
      mdl[ln].last_w     = ws;
    end
  endtask

  task automatic cycle(input bit wv, input logic [7:0] wd, input bit rq);
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    drive(wv, wd, rq);
    model_step(0, wv, wd, rq);
    model_step(1, wv, wd, rq);
  endtask

  // Reset asserted between edges; any in-flight transfer is forgotten.
  task automatic reset_mid();
    @(posedge clk);
    cyc++;
    #1;
    drive(1'b0, 8'h00, 1'b0);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      bus_in_arr[c] = (c < 300) ? 8'h3C : 8'($urandom);
    end
    model_reset();
    drive(1'b0, 8'h00, 1'b0);
    reset_mid();

    // first write after reset: turnaround from receive to transmit
    cycle(1'b1, 8'hA5, 1'b0);
    repeat (6) cycle(1'b0, 8'h00, 1'b0);

    // back-to-back writes in the same direction
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h02, 1'b0);
    cycle(1'b1, 8'h02, 1'b0);
    repeat (4) cycle(1'b0, 8'h00, 1'b0);

    // read after write, bus_in = 0x3C
    cycle(1'b0, 8'h00, 1'b1);
    repeat (8) cycle(1'b0, 8'h00, 1'b0);

    // contention held from reset
    reset_mid();
    repeat (24) cycle(1'b1, 8'h11, 1'b1);
    repeat (10) cycle(1'b0, 8'h00, 1'b0);

    // reset during the DRIVE of the TURN_CYC=3 controller
    cycle(1'b0, 8'h00, 1'b1);
    repeat (8) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h77, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (evq[1].size() > 0 && evq[1][0].cyc == cyc + 1) break;
      cycle(1'b0, 8'h00, 1'b0);
    end
    reset_mid();
    repeat (6) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h77, 1'b0);
    repeat (8) cycle(1'b0, 8'h00, 1'b0);

    // randomized traffic with occasional resets
    repeat (2000) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_mid();
      end else begin
        cycle($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 1) == 1);
      end
    end
    repeat (10) cycle(1'b0, 8'h00, 1'b0);
    sim_done = 1'b1;
  end

  // --------------------------------------------------------------- monitor --
  task automatic mon_lane(input int ln, input logic ce, input logic sr, input logic oe,
                          input logic wrr, input logic rdv, input logic [7:0] bo,
                          input logic [7:0] rdd);
    string p;
    bit    ce_e, rdv_e;
    ev_t   e;
    p = (ln == 0) ? "tc1" : "tc3";
    if (rst) begin
      check({p, " rst ce"},       32'(ce),  32'd0);
      check({p, " rst sr"},       32'(sr),  32'd0);
      check({p, " rst bus_oe"},   32'(oe),  32'd0);
      check({p, " rst wr_ready"}, 32'(wrr), 32'd0);
      check({p, " rst rd_valid"}, 32'(rdv), 32'd0);
      check({p, " rst bus_out"},  32'(bo),  32'd0);
      check({p, " rst rd_data"},  32'(rdd), 32'd0);
      prev_sr[ln] = 1'b0;
      prev_ce[ln] = 1'b0;
      return;
    end
    check({p, " wr_ready"}, 32'(wrr), 32'(exp_wrr[ln]));
    check({p, " sr"},       32'(sr),  32'(exp_sr[ln]));
    ce_e = (evq[ln].size() > 0) && (evq[ln][0].cyc == cyc);
    check({p, " ce"}, 32'(ce), 32'(ce_e));
    if (ce_e) begin
      e = evq[ln].pop_front();
      check({p, " bus_oe"}, 32'(oe), 32'(e.is_w));
      if (e.is_w) check({p, " bus_out"}, 32'(bo), 32'(e.data));
    end else begin
      check({p, " bus_oe idle"}, 32'(oe), 32'd0);
    end
    rdv_e = (rdq[ln].size() > 0) && (rdq[ln][0].cyc == cyc);
    check({p, " rd_valid"}, 32'(rdv), 32'(rdv_e));
    if (rdv_e) begin
      e = rdq[ln].pop_front();
      check({p, " rd_data"}, 32'(rdd), 32'(e.data));
    end
    check({p, " oe without sr"}, 32'(oe & ~sr), 32'd0);
    check({p, " sr moved with ce"}, 32'((prev_ce[ln] || ce) && (sr != prev_sr[ln])), 32'd0);
    prev_sr[ln] = sr;
    prev_ce[ln] = ce;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon_lane(0, if1.ce, if1.sr, if1.bus_oe, if1.wr_ready, if1.rd_valid, if1.bus_out, if1.rd_data);
      mon_lane(1, if3.ce, if3.sr, if3.bus_oe, if3.wr_ready, if3.rd_valid, if3.bus_out, if3.rd_data);
      if (sim_done) begin
        check("tc1 transfers outstanding", 32'(evq[0].size() + rdq[0].size()), 32'd0);
        check("tc3 transfers outstanding", 32'(evq[1].size() + rdq[1].size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
